sysbus_arbiter: RTL and testbench

Two-client arbiter and transaction sequencer for the single Sysbus port of the core. Client 0 is instruction fetch; client 1 is data memory. The block accepts one read request at a time, drives the bus request handshake, and steers the BEATS-beat response burst back to the granted client. It owns bus_reqcyc, bus_req, bus_reqtag and bus_respack at top level.

---
 rtl/sysbus_arbiter.sv | 149 ++++++++++++++
 tb/tb_sysbus_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// Two-client (fetch/data) Sysbus read arbiter and BEATS-beat response sequencer.
// Optional `ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed data-first priority.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      i_req,
    input  logic [BUS_DATA_WIDTH-1:0] i_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  i_tag,
    output logic                      i_grant,
    output logic                      i_rvalid,
    output logic                      i_rlast,
    output logic [BUS_DATA_WIDTH-1:0] i_rdata,

    input  logic                      d_req,
    input  logic [BUS_DATA_WIDTH-1:0] d_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  d_tag,
    output logic                      d_grant,
    output logic                      d_rvalid,
    output logic                      d_rlast,
    output logic [BUS_DATA_WIDTH-1:0] d_rdata,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                    r_state;
    logic                      r_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] r_addr;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic                      r_owner;    // 0 = fetch, 1 = data
    logic [CNT_W-1:0]          r_beat;
`ifdef ARB_ROUND_ROBIN_EN
    logic                      r_rr_ptr;   // last granted client
`endif

    logic w_any_req;
    logic w_winner;
    logic w_in_resp;
    logic w_beat;
    logic w_ack;
    logic w_last;
    logic w_unused;

    // Response tags are not checked; fold them into an intentionally unused net.
    assign w_unused = ^bus_resptag;

    assign w_any_req = i_req | d_req;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) w_winner = ~r_rr_ptr;
        else                w_winner = d_req;
`else
        w_winner = d_req;
`endif
    end

    assign w_in_resp = (r_state == S_WAIT) || (r_state == S_RESP);
    assign w_beat    = w_in_resp & bus_respcyc;
    assign w_ack     = (r_state == S_REQ) & bus_reqack;
    assign w_last    = w_beat & (r_beat == LAST_BEAT);

    // NOTE: grant/rvalid/respack are combinational on the bus handshake so a
    // beat is consumed and forwarded in the same cycle it is presented.
    assign bus_reqcyc  = r_reqcyc;
    assign bus_req     = r_addr;
    assign bus_reqtag  = r_tag;
    assign bus_respack = w_beat;

    assign i_grant  = w_ack & ~r_owner;
    assign d_grant  = w_ack &  r_owner;
    assign i_rvalid = w_beat & ~r_owner;
    assign d_rvalid = w_beat &  r_owner;
    assign i_rlast  = w_last & ~r_owner;
    assign d_rlast  = w_last &  r_owner;
    assign i_rdata  = i_rvalid ? bus_resp : '0;
    assign d_rdata  = d_rvalid ? bus_resp : '0;

    // NOTE: reset is synchronous, so it is sampled inside the clocked branch
    // rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_reqcyc <= 1'b0;
            r_addr   <= '0;
            r_tag    <= '0;
            r_owner  <= 1'b0;
            r_beat   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_winner;
                        r_addr   <= w_winner ? d_addr : i_addr;
                        r_tag    <= w_winner ? d_tag  : i_tag;
                        r_reqcyc <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_reqack) begin
                        r_reqcyc <= 1'b0;
                        r_state  <= S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_ptr <= r_owner;
`endif
                    end
                end
                S_WAIT, S_RESP: begin
                    if (bus_respcyc) begin
                        if (r_beat == LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat  <= r_beat + CNT_W'(1);
                            r_state <= S_RESP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed self-checking bench for sysbus_arbiter: single burst, ties, gaps, ack stall, mid-burst reset.
// Expected tie order follows `ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_sysbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req;
    logic [63:0] i_addr, d_addr;
    logic [12:0] i_tag, d_tag;
    logic        i_grant, i_rvalid, i_rlast;
    logic        d_grant, d_rvalid, d_rlast;
    logic [63:0] i_rdata, d_rdata;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [13:0] GAP_PAT = 14'h2B59;  // 1,0,0,1,1,0,1,0,1,1,0,1,0,1 from bit 0

    sysbus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_tag(i_tag),
        .i_grant(i_grant), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_tag(d_tag),
        .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {bus_reqcyc, bus_respack, i_grant, d_grant,
                              i_rvalid, d_rvalid, i_rlast, d_rlast}, 8'h00);
        check({tag, "_bus_req"}, bus_req, 64'h0);
        check({tag, "_bus_reqtag"}, {51'h0, bus_reqtag}, 64'h0);
        check({tag, "_rdata"}, i_rdata | d_rdata, 64'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        tick();
        tick();
        reset = 1'b0;
        check_idle_outputs("reset");
    endtask

    // Starts in IDLE with request(s) already driven; n_beats < 8 stops mid-burst.
    task automatic run_txn(input bit exp_owner, input logic [63:0] exp_addr,
                           input logic [12:0] exp_tag, input int ack_delay,
                           input bit gapped, input int n_beats, input bit drop_req);
        int  beat;
        logic rc;
        logic [63:0] exp_data;
        check("idle_reqcyc", bus_reqcyc, 0);
        tick();
        check("reqcyc_rise", bus_reqcyc, 1);
        check("bus_req", bus_req, exp_addr);
        check("bus_reqtag", bus_reqtag, exp_tag);
        bus_respcyc = 1'b1;  // must be ignored while requesting
        for (int c = 0; c < ack_delay; c++) begin
            #1;
            check("req_hold", {bus_reqcyc, i_grant, d_grant, bus_respack, i_rvalid, d_rvalid}, 6'b100000);
            check("req_addr_stable", bus_req, exp_addr);
            check("req_tag_stable", bus_reqtag, exp_tag);
            tick();
        end
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b1;
        #1;
        check("grant", {i_grant, d_grant}, exp_owner ? 2'b01 : 2'b10);
        tick();
        bus_reqack = 1'b0;
        if (drop_req) begin
            if (exp_owner) d_req = 1'b0;
            else           i_req = 1'b0;
        end
        #1;
        check("reqcyc_fall", {bus_reqcyc, i_grant, d_grant}, 3'b000);
        beat = 0;
        for (int c = 0; c < 40 && beat < n_beats; c++) begin
            rc = gapped ? GAP_PAT[c % 14] : 1'b1;
            bus_respcyc = rc;
            bus_resp    = {32'hCAFE_F00D, 32'(beat)};
            exp_data    = rc ? {32'hCAFE_F00D, 32'(beat)} : 64'h0;
            #1;
            check("respack", bus_respack, rc);
            check("rvalid", {i_rvalid, d_rvalid}, exp_owner ? {1'b0, rc} : {rc, 1'b0});
            check("rlast", {i_rlast, d_rlast},
                  (rc && beat == 7) ? (exp_owner ? 2'b01 : 2'b10) : 2'b00);
            check("rdata_owner", exp_owner ? d_rdata : i_rdata, exp_data);
            check("rdata_other", exp_owner ? i_rdata : d_rdata, 64'h0);
            tick();
            if (rc) beat++;
        end
        bus_respcyc = 1'b0;
        if (beat != n_beats) check("beat_budget", beat, n_beats);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        i_addr = 64'h1000; i_tag = 13'h0AA;
        d_addr = 64'h2000; d_tag = 13'h155;
        apply_reset();

        // Single fetch: reqcyc high cycles 1-3, ack in cycle 3, 8 back-to-back beats.
        i_req = 1'b1;
        run_txn(1'b0, 64'h1000, 13'h0AA, 2, 1'b0, 8, 1'b1);
        bus_respcyc = 1'b1;  // ignored in IDLE
        #1;
        check("idle_respack", {bus_respack, i_rvalid, d_rvalid}, 3'b000);
        tick();
        check("idle_stays", bus_reqcyc, 0);
        bus_respcyc = 1'b0;

        // Reset after beat 3, then a clean full burst.
        i_req = 1'b1; i_addr = 64'h3000;
        run_txn(1'b0, 64'h3000, 13'h0AA, 1, 1'b0, 4, 1'b1);
        reset = 1'b1; bus_respcyc = 1'b1; bus_resp = 64'hDEAD;
        tick();
        reset = 1'b0;
        check_idle_outputs("mid_reset");
        tick();
        check("post_reset_noack", {bus_respack, i_rvalid, bus_reqcyc}, 3'b000);
        bus_respcyc = 1'b0;
        i_req = 1'b1; i_addr = 64'h1000;
        run_txn(1'b0, 64'h1000, 13'h0AA, 0, 1'b0, 8, 1'b1);

        // Three tied transactions with both clients held requesting.
        apply_reset();
        i_req = 1'b1; d_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        run_txn(1'b0, 64'h1000, 13'h0AA, 0, 1'b0, 8, 1'b0);
        run_txn(1'b1, 64'h2000, 13'h155, 0, 1'b0, 8, 1'b0);
        run_txn(1'b0, 64'h1000, 13'h0AA, 0, 1'b0, 8, 1'b0);
`else
        run_txn(1'b1, 64'h2000, 13'h155, 0, 1'b0, 8, 1'b0);
        run_txn(1'b1, 64'h2000, 13'h155, 0, 1'b0, 8, 1'b0);
        run_txn(1'b1, 64'h2000, 13'h155, 0, 1'b0, 8, 1'b0);
`endif
        d_req = 1'b0;
        run_txn(1'b0, 64'h1000, 13'h0AA, 0, 1'b0, 8, 1'b1);

        // Response gaps: 8 ones spread over 14 cycles.
        i_req = 1'b1;
        run_txn(1'b0, 64'h1000, 13'h0AA, 0, 1'b1, 8, 1'b1);

        // Ack stall of 10 cycles on a data request.
        d_req = 1'b1;
        run_txn(1'b1, 64'h2000, 13'h155, 10, 1'b0, 8, 1'b1);
        #1;
        check("final_idle", {bus_reqcyc, bus_respack, i_grant, d_grant}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
